// File: rtl/calc_n_pkg.sv
// Shared command/response encodings and per-port state type for the calc_n block.
package calc_n_pkg;

   localparam int CMD_W  = 4;
   localparam int RESP_W = 2;

   localparam logic [CMD_W-1:0] CMD_NONE = 4'd0;
   localparam logic [CMD_W-1:0] CMD_ADD  = 4'd1;
   localparam logic [CMD_W-1:0] CMD_SUB  = 4'd2;
   localparam logic [CMD_W-1:0] CMD_SHL  = 4'd5;
   localparam logic [CMD_W-1:0] CMD_SHR  = 4'd6;

   localparam logic [RESP_W-1:0] RESP_NONE = 2'b00;
   localparam logic [RESP_W-1:0] RESP_OK   = 2'b01;
   localparam logic [RESP_W-1:0] RESP_ERR  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OP2  = 2'd1,
      ST_PEND = 2'd2,
      ST_RESP = 2'd3
   } port_state_t;

endpackage

// File: rtl/calc_n_port.sv
// Per-port request FSM: captures command/op1, then op2, waits for a grant and
// presents the registered result for one cycle.
module calc_n_port
   import calc_n_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CMD_W-1:0]  cmd,
   input  logic [DW-1:0]     data,
   input  logic              gnt,
   input  logic [RESP_W-1:0] res_code,
   input  logic [DW-1:0]     res_data,
   output logic              pend,
   output logic [CMD_W-1:0]  cmd_q,
   output logic [DW-1:0]     op1_q,
   output logic [DW-1:0]     op2_q,
   output logic [RESP_W-1:0] resp,
   output logic [DW-1:0]     resp_data
);

   port_state_t       state, state_nxt;
   logic              op1_ld, op2_ld;
   logic [RESP_W-1:0] res_code_q;
   logic [DW-1:0]     res_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand and result holding registers carry no reset: they are only
   // observable once the FSM has walked through the states that load them.
   always_ff @(posedge clk) begin
      if (op1_ld) begin
         cmd_q <= cmd;
         op1_q <= data;
      end
      if (op2_ld) begin
         op2_q <= data;
      end
      if (gnt) begin
         res_code_q <= res_code;
         res_data_q <= res_data;
      end
   end

   always_comb begin
      state_nxt = state;
      op1_ld    = 1'b0;
      op2_ld    = 1'b0;
      case (state)
         ST_IDLE, ST_RESP: begin
            if (cmd != CMD_NONE) begin
               op1_ld    = 1'b1;
               state_nxt = ST_OP2;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_OP2: begin
            op2_ld    = 1'b1;
            state_nxt = ST_PEND;
         end
         ST_PEND: begin
            if (gnt) begin
               state_nxt = ST_RESP;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign pend      = (state == ST_PEND);
   assign resp      = (state == ST_RESP) ? res_code_q : RESP_NONE;
   assign resp_data = (state == ST_RESP) ? res_data_q : '0;

endmodule

// File: rtl/calc_n.sv
// Multi-port calculator: NPORTS request FSMs share one ALU through a
// round-robin arbiter. Define CALC_N_SHIFT_EN to enable the shift commands.
module calc_n
   import calc_n_pkg::*;
#(
   parameter int NPORTS = 4,
   parameter int DW     = 32
) (
   input  logic                     c_clk,
   input  logic                     reset,
   input  logic [NPORTS*CMD_W-1:0]  req_cmd_in,
   input  logic [NPORTS*DW-1:0]     req_data_in,
   output logic [NPORTS*RESP_W-1:0] out_resp,
   output logic [NPORTS*DW-1:0]     out_data
);

   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
`ifdef CALC_N_SHIFT_EN
   localparam int SW = $clog2(DW);
`endif

   if (NPORTS < 1 || NPORTS > 8) begin : g_bad_nports
      $error("calc_n: NPORTS must be in 1..8");
   end
   if (DW < 8 || DW > 64 || (DW & (DW - 1)) != 0) begin : g_bad_dw
      $error("calc_n: DW must be a power of two in 8..64");
   end

   logic [NPORTS-1:0] pend;
   logic [NPORTS-1:0] gnt;
   logic [CMD_W-1:0]  cmd_q [NPORTS];
   logic [DW-1:0]     op1_q [NPORTS];
   logic [DW-1:0]     op2_q [NPORTS];
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     gnt_idx_p0;
   logic              vld_p0;
   logic [DW+1:0]     alu_p0;

   // Returns {resp_code, result}; every error case forces the result to zero.
   function automatic logic [DW+1:0] alu_eval(input logic [CMD_W-1:0] op,
                                              input logic [DW-1:0]    a,
                                              input logic [DW-1:0]    b);
      logic [DW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      case (op)
         CMD_ADD: alu_eval = sum[DW] ? {RESP_ERR, {DW{1'b0}}} : {RESP_OK, sum[DW-1:0]};
         CMD_SUB: alu_eval = (b > a) ? {RESP_ERR, {DW{1'b0}}} : {RESP_OK, a - b};
`ifdef CALC_N_SHIFT_EN
         CMD_SHL: alu_eval = {RESP_OK, a << b[SW-1:0]};
         CMD_SHR: alu_eval = {RESP_OK, a >> b[SW-1:0]};
`endif
         default: alu_eval = {RESP_ERR, {DW{1'b0}}};
      endcase
   endfunction

   // Stage p0: pick one pending port starting at ptr and evaluate its operation.
   always_comb begin
      logic [PW-1:0] idx;
      gnt        = '0;
      gnt_idx_p0 = '0;
      vld_p0     = 1'b0;
      idx        = '0;
      for (int i = 0; i < NPORTS; i++) begin
         idx = PW'((int'(ptr) + i) % NPORTS);
         if (!vld_p0 && pend[idx]) begin
            vld_p0     = 1'b1;
            gnt_idx_p0 = idx;
            gnt[idx]   = 1'b1;
         end
      end
   end

   assign alu_p0 = alu_eval(cmd_q[gnt_idx_p0], op1_q[gnt_idx_p0], op2_q[gnt_idx_p0]);

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (vld_p0) begin
         ptr <= (gnt_idx_p0 == PW'(NPORTS - 1)) ? '0 : gnt_idx_p0 + 1'b1;
      end
   end

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      calc_n_port #(
         .DW(DW)
      ) u_port (
         .clk      (c_clk),
         .rst      (reset),
         .cmd      (req_cmd_in[p*CMD_W +: CMD_W]),
         .data     (req_data_in[p*DW +: DW]),
         .gnt      (gnt[p]),
         .res_code (alu_p0[DW+1:DW]),
         .res_data (alu_p0[DW-1:0]),
         .pend     (pend[p]),
         .cmd_q    (cmd_q[p]),
         .op1_q    (op1_q[p]),
         .op2_q    (op2_q[p]),
         .resp     (out_resp[p*RESP_W +: RESP_W]),
         .resp_data(out_data[p*DW +: DW])
      );
   end

endmodule

// File: tb/tb_calc_n.sv
// Scoreboard bench for calc_n (NPORTS=4, DW=32); honours CALC_N_SHIFT_EN.
module tb_calc_n;

   localparam int NP = 4;
   localparam int W  = 32;

   typedef struct {
      int          port;
      logic [1:0]  resp;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic              c_clk = 1'b0;
   logic              reset;
   logic [NP*4-1:0]   req_cmd_in;
   logic [NP*W-1:0]   req_data_in;
   logic [NP*2-1:0]   out_resp;
   logic [NP*W-1:0]   out_data;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   m_ptr    = 0;
   exp_t sb[$];

   logic [3:0]  t_cmd [NP];
   logic [31:0] t_a   [NP];
   logic [31:0] t_b   [NP];

   logic [1:0]  mon_r;
   logic [31:0] mon_d;
   exp_t        mon_e;

   calc_n #(.NPORTS(NP), .DW(W)) dut (
      .c_clk      (c_clk),
      .reset      (reset),
      .req_cmd_in (req_cmd_in),
      .req_data_in(req_data_in),
      .out_resp   (out_resp),
      .out_data   (out_data)
   );

   always #5 c_clk = ~c_clk;
   always @(posedge c_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (c)
         4'd1: return s[32] ? {2'b10, 32'h0} : {2'b01, s[31:0]};
         4'd2: return (b > a) ? {2'b10, 32'h0} : {2'b01, a - b};
`ifdef CALC_N_SHIFT_EN
         4'd5: return {2'b01, a << b[4:0]};
         4'd6: return {2'b01, a >> b[4:0]};
`endif
         default: return {2'b10, 32'h0};
      endcase
   endfunction

   always @(negedge c_clk) begin
      if (!reset) begin
         for (int p = 0; p < NP; p++) begin
            mon_r = out_resp[p*2 +: 2];
            mon_d = out_data[p*W +: W];
            if (mon_r != 2'b00) begin
               if (sb.size() == 0) begin
                  check("unexpected_resp", {62'b0, mon_r}, 64'd0);
               end else begin
                  mon_e = sb.pop_front();
                  check("resp_port", p, mon_e.port);
                  check("resp_code", {62'b0, mon_r}, {62'b0, mon_e.resp});
                  check("resp_data", {32'b0, mon_d}, {32'b0, mon_e.data});
                  check("resp_cycle", cyc, mon_e.due);
               end
            end else begin
               check("idle_data", {32'b0, mon_d}, 64'd0);
            end
         end
      end
   end

   task automatic set_op(input int p, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
      t_cmd[p] = c;
      t_a[p]   = a;
      t_b[p]   = b;
   endtask

   // Issue on every port in mask at once; the arbiter must be idle beforehand.
   task automatic issue(input logic [3:0] mask);
      int   base;
      int   rank;
      int   last;
      int   idx;
      exp_t e;
      logic [33:0] r;
      @(negedge c_clk);
      base = cyc + 3;
      rank = 0;
      last = -1;
      for (int k = 0; k < NP; k++) begin
         idx = (m_ptr + k) % NP;
         if (mask[idx]) begin
            r      = model(t_cmd[idx], t_a[idx], t_b[idx]);
            e.port = idx;
            e.resp = r[33:32];
            e.data = r[31:0];
            e.due  = base + rank;
            sb.push_back(e);
            rank++;
            last = idx;
         end
      end
      if (last >= 0) m_ptr = (last + 1) % NP;
      for (int p = 0; p < NP; p++) begin
         req_cmd_in[p*4 +: 4]  = mask[p] ? t_cmd[p] : 4'd0;
         req_data_in[p*W +: W] = mask[p] ? t_a[p] : 32'd0;
      end
      @(negedge c_clk);
      req_cmd_in = '0;
      for (int p = 0; p < NP; p++) begin
         req_data_in[p*W +: W] = mask[p] ? t_b[p] : 32'd0;
      end
      @(negedge c_clk);
      req_data_in = '0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge c_clk);
         n++;
      end
      check("drain", sb.size(), 0);
      sb.delete();
      repeat (2) @(negedge c_clk);
   endtask

   task automatic pulse_reset();
      @(negedge c_clk);
      reset = 1'b1;
      @(negedge c_clk);
      check("rst_resp", {56'b0, out_resp}, 64'd0);
      check("rst_ptr", {62'b0, dut.ptr}, 64'd0);
      reset = 1'b0;
      m_ptr = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      req_cmd_in  = '0;
      req_data_in = '0;
      repeat (3) @(negedge c_clk);
      check("reset_resp", {56'b0, out_resp}, 64'd0);
      check("reset_data_lo", out_data[63:0], 64'd0);
      check("reset_data_hi", out_data[127:64], 64'd0);
      check("reset_ptr", {62'b0, dut.ptr}, 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge c_clk);

      // Uncontended add on port 0.
      set_op(0, 4'd1, 32'h1, 32'h1FFF_FFFF);
      issue(4'b0001);
      drain(20);

      // Overflow / underflow / equal / normal subtract.
      set_op(0, 4'd1, 32'hFFFF_FFFF, 32'h1);
      issue(4'b0001);
      drain(20);
      set_op(0, 4'd2, 32'h1, 32'hF);
      issue(4'b0001);
      drain(20);
      set_op(0, 4'd2, 32'hF, 32'h1);
      issue(4'b0001);
      drain(20);
      set_op(0, 4'd2, 32'h55, 32'h55);
      issue(4'b0001);
      drain(20);

      // Invalid commands and shifts, issued concurrently.
      set_op(0, 4'd6, 32'h80, 32'h3);
      set_op(1, 4'd3, 32'h1, 32'h2);
      set_op(2, 4'd4, 32'h1, 32'h2);
      set_op(3, 4'd5, 32'h1, 32'h4);
      issue(4'b1111);
      drain(30);
      set_op(2, 4'd15, 32'h7, 32'h7);
      issue(4'b0100);
      drain(20);

      // All ports right after reset: consecutive answers in port order.
      pulse_reset();
      for (int p = 0; p < NP; p++) set_op(p, 4'd1, 32'h1, p);
      issue(4'b1111);
      drain(30);

      // Ports 1 and 3 together: port 1 first, pointer wraps to 0.
      set_op(1, 4'd1, 32'h10, 32'h1);
      set_op(3, 4'd1, 32'h30, 32'h3);
      issue(4'b1010);
      drain(30);
      check("ptr_end", {62'b0, dut.ptr}, 64'd0);

      // Reset while port 2 is pending: its request must vanish.
      set_op(1, 4'd1, 32'h2, 32'h2);
      issue(4'b0010);
      drain(20);
      @(negedge c_clk);
      req_cmd_in[11:8]   = 4'd1;
      req_data_in[95:64] = 32'h7;
      @(negedge c_clk);
      req_cmd_in         = '0;
      req_data_in[95:64] = 32'h8;
      @(negedge c_clk);
      req_data_in        = '0;
      check("pend_before_rst", {63'b0, dut.pend[2]}, 64'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_resp", {56'b0, out_resp}, 64'd0);
      check("mid_rst_data_lo", out_data[63:0], 64'd0);
      check("mid_rst_data_hi", out_data[127:64], 64'd0);
      check("mid_rst_ptr", {62'b0, dut.ptr}, 64'd0);
      @(negedge c_clk);
      reset = 1'b0;
      m_ptr = 0;
      repeat (6) @(negedge c_clk);
      check("post_rst_quiet", {56'b0, out_resp}, 64'd0);
      set_op(2, 4'd1, 32'h7, 32'h8);
      issue(4'b0100);
      drain(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_n.md
CALC_N -- requirements
Module: calc_n

Interface
REQ-001 SHALL have parameter NPORTS, default 4, meaning number of request ports (legal 1..8).
REQ-002 SHALL have parameter DW, default 32, meaning operand/result width in bits (legal 8..64, power of two).
REQ-003 SHALL have port c_clk, input, 1 bit, meaning the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port req_cmd_in, input, NPORTS*4 bits, meaning per-port command; port p uses the p-th 4-bit field from index 0.
REQ-006 SHALL have port req_data_in, input, NPORTS*DW bits, meaning per-port operand, sliced the same way.
REQ-007 SHALL have port out_resp, output, NPORTS*2 bits, meaning per-port response code, sliced the same way.
REQ-008 SHALL have port out_data, output, NPORTS*DW bits, meaning per-port result, sliced the same way.

Function
REQ-009 SHALL use command codes 0 (none), 1 (add), 2 (subtract), 5 (shift left), 6 (shift right logical); every other nonzero code is invalid.
REQ-010 SHALL use response codes 00 (none), 01 (success), 10 (overflow, underflow or invalid command); 11 is reserved and never driven.
REQ-011 SHALL run a 4-state FSM per port: IDLE, OP2, PEND, RESP.
REQ-012 SHALL, in IDLE or RESP, on a nonzero cmd at an edge, latch cmd and data as op1 and go to OP2.
REQ-013 SHALL, in OP2, latch data as op2 at the next edge, ignore cmd, and go to PEND.
REQ-014 SHALL ignore cmd while a port is in OP2 or PEND, allowing one outstanding request per port.
REQ-015 SHALL have a round-robin arbiter grant exactly one PEND port per cycle, searching from pointer ptr; ptr becomes granted+1 mod NPORTS.
REQ-016 SHALL compute the granted result combinationally, register it at the grant edge, and move that port to RESP.
REQ-017 SHALL drive out_resp/out_data for a port in RESP for exactly one cycle, and 00/0 otherwise.
REQ-018 SHALL give an uncontended response in the cycle after the edge following op2 capture, with each cycle of arbitration wait adding one cycle.
REQ-019 SHALL make add overflow (carry out of DW bits) give resp 10 with data 0.
REQ-020 SHALL make subtract with op2 > op1 give resp 10 with data 0, and op1 == op2 give 01 with data 0.
REQ-021 SHALL shift by op2[log2(DW)-1:0], discard the shifted-out bits, and always give resp 01.
REQ-022 SHALL give resp 10 with data 0 for an invalid command, after the normal latency.

Reset
REQ-023 SHALL, while reset is high, immediately drive every FSM to IDLE, ptr to 0, and all out_resp/out_data to 0.
REQ-024 SHALL discard requests in progress at reset and never produce a response for them.

Configuration
REQ-025 SHALL, with CALC_N_SHIFT_EN defined, implement commands 5 and 6 as in REQ-021.
REQ-026 SHALL, without CALC_N_SHIFT_EN, treat commands 5 and 6 as invalid and include no shifter logic.

Structure
REQ-027 SHALL place command codes, response codes and the port-state enum in package calc_n_pkg.
REQ-028 SHALL implement the per-port FSM and operand latches as sub-module calc_n_port, instantiated NPORTS times; the arbiter and ALU stay in calc_n.

Verification
REQ-029 SHALL check: port0 add 0x1 then 0x1FFF_FFFF (DW=32) -> resp 01, data 0x2000_0000, at uncontended latency.
REQ-030 SHALL check: add 0xFFFF_FFFF + 0x1 -> resp 10, data 0; sub 0x1 - 0xF -> resp 10, data 0; sub 0xF - 0x1 -> 01, 0xE.
REQ-031 SHALL check: cmd 3 and cmd 4 -> resp 10; cmd 5 with 0x1, 0x4 -> 01, 0x10 with CALC_N_SHIFT_EN, and resp 10 without it.
REQ-032 SHALL check: all four ports issue add 0x1 + port index simultaneously after reset -> responses on four consecutive cycles in order port0..3, data 1,2,3,4.
REQ-033 SHALL check: ports 1 and 3 issue simultaneously right after the previous round -> port1 answers before port3, and ptr ends at 0.
REQ-034 SHALL check: reset pulsed while port2 is in PEND -> no response appears, all outputs are 0, and a fresh add on port2 then completes normally.
